crypto_block_responder: RTL and testbench

Core-side end of the crypto block interface: receives key/text/start from the register block and returns cipher/ready/done/idle. It sequences one multi-cycle cipher core (load pulse in, busy out), captures the result, and drives a trigger window of configurable pre/post padding for capture alignment. It also provides a watchdog so a hung core cannot stall the interface.

---
 rtl/crypto_block_responder.sv | 149 ++++++++++++++
 tb/tb_crypto_block_responder.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/crypto_block_responder.sv
// Core-side responder of the crypto block interface: sequences one multi-cycle
// cipher core, captures its result, frames it in a trigger window and bounds it with a watchdog.
module crypto_block_responder #(
  parameter int TEXT_WIDTH   = 128,
  parameter int KEY_WIDTH    = 128,
  parameter int CIPHER_WIDTH = 128,
  parameter int TRIG_PRE     = 2,
  parameter int TRIG_POST    = 2,
  parameter int TIMEOUT      = 1023
) (
  input  logic                    crypto_clk,
  input  logic                    crypto_rstn,
  input  logic [KEY_WIDTH-1:0]    crypto_keyout,
  input  logic [TEXT_WIDTH-1:0]   crypto_textout,
  input  logic                    crypto_start,
  output logic [CIPHER_WIDTH-1:0] crypto_cipherin,
  output logic                    crypto_ready,
  output logic                    crypto_done,
  output logic                    crypto_idle,
  output logic                    trigger,
  output logic                    timeout,
  output logic [KEY_WIDTH-1:0]    core_key,
  output logic [TEXT_WIDTH-1:0]   core_data,
  output logic                    core_load,
  input  logic [CIPHER_WIDTH-1:0] core_result,
  input  logic                    core_busy
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_LOAD = 3'd2,
    ST_RUN  = 3'd3,
    ST_POST = 3'd4
  } state_t;

  localparam logic [15:0] PRE_LAST  = 16'((TRIG_PRE  > 0) ? TRIG_PRE  - 1 : 0);
  localparam logic [15:0] POST_LAST = 16'((TRIG_POST > 0) ? TRIG_POST - 1 : 0);
  localparam logic [15:0] WDOG_MAX  = 16'(TIMEOUT);

  state_t      r_state;
  logic        r_start_d;
  logic        r_first;
  logic [15:0] r_cnt;
  logic [15:0] r_wdog;

  logic        w_accept;
  logic        w_capture;
  logic        w_abort;
  logic [15:0] w_wdog_inc;

  // Start-edge acceptance and RUN exit decisions.
  always_comb begin
    w_wdog_inc = r_wdog + 16'd1;
    w_accept   = (r_state == ST_IDLE) && crypto_start && !r_start_d;
    w_capture  = (r_state == ST_RUN) && !r_first && !core_busy;
    // The first RUN cycle cannot capture, but a stuck-high busy still counts toward the watchdog.
    w_abort    = (r_state == ST_RUN) && !w_capture && core_busy && (w_wdog_inc >= WDOG_MAX);
  end

  // Sequencer FSM with all interface outputs registered.
  always_ff @(posedge crypto_clk) begin
    if (!crypto_rstn) begin
      r_state         <= ST_IDLE;
      r_start_d       <= 1'b0;
      r_first         <= 1'b0;
      r_cnt           <= 16'd0;
      r_wdog          <= 16'd0;
      crypto_cipherin <= '0;
      crypto_ready    <= 1'b1;
      crypto_idle     <= 1'b1;
      crypto_done     <= 1'b0;
      trigger         <= 1'b0;
      timeout         <= 1'b0;
      core_key        <= '0;
      core_data       <= '0;
      core_load       <= 1'b0;
    end else begin
      r_start_d <= crypto_start;
      core_load <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            core_key     <= crypto_keyout;
            core_data    <= crypto_textout;
            crypto_done  <= 1'b0;
            timeout      <= 1'b0;
            crypto_ready <= 1'b0;
            crypto_idle  <= 1'b0;
            trigger      <= 1'b1;
            if (TRIG_PRE == 0) begin
              r_state   <= ST_LOAD;
              core_load <= 1'b1;
            end else begin
              r_state <= ST_PRE;
              r_cnt   <= PRE_LAST;
            end
          end
        end
        ST_PRE: begin
          if (r_cnt == 16'd0) begin
            r_state   <= ST_LOAD;
            core_load <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        ST_LOAD: begin
          r_state <= ST_RUN;
          r_wdog  <= 16'd0;
          r_first <= 1'b1;
        end
        ST_RUN: begin
          r_wdog  <= w_wdog_inc;
          r_first <= 1'b0;
          if (w_capture || w_abort) begin
            crypto_cipherin <= w_capture ? core_result : '0;
            timeout         <= w_abort;
            if (TRIG_POST == 0) begin
              r_state      <= ST_IDLE;
              crypto_ready <= 1'b1;
              crypto_idle  <= 1'b1;
              crypto_done  <= 1'b1;
              trigger      <= 1'b0;
            end else begin
              r_state <= ST_POST;
              r_cnt   <= POST_LAST;
            end
          end
        end
        ST_POST: begin
          if (r_cnt == 16'd0) begin
            r_state      <= ST_IDLE;
            crypto_ready <= 1'b1;
            crypto_idle  <= 1'b1;
            crypto_done  <= 1'b1;
            trigger      <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_crypto_block_responder.sv
// Bench for crypto_block_responder: two builds (2/2 and 0/0 trigger padding, watchdog 20)
// checked every cycle against an operation-timeline model, plus hand-computed literals.
module tb_crypto_block_responder;

  localparam logic [127:0] AES_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] AES_PT  = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] AES_CT  = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
  localparam int           WD      = 20;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         start = 1'b0;
  logic [127:0] key = 128'd0;
  logic [127:0] text = 128'd0;

  logic [127:0] cipher [2];
  logic [127:0] ckey [2];
  logic [127:0] cdata [2];
  logic [127:0] cres [2];
  logic         ready [2];
  logic         idle [2];
  logic         done [2];
  logic         trig [2];
  logic         tmo [2];
  logic         load [2];
  logic         busy [2];

  int           cfg_b = 10;
  bit           cfg_stuck = 1'b0;
  logic [127:0] cfg_res = 128'd0;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  crypto_block_responder #(.TRIG_PRE(2), .TRIG_POST(2), .TIMEOUT(WD)) u_dut0 (
    .crypto_clk(clk), .crypto_rstn(rstn), .crypto_keyout(key), .crypto_textout(text),
    .crypto_start(start), .crypto_cipherin(cipher[0]), .crypto_ready(ready[0]),
    .crypto_done(done[0]), .crypto_idle(idle[0]), .trigger(trig[0]), .timeout(tmo[0]),
    .core_key(ckey[0]), .core_data(cdata[0]), .core_load(load[0]),
    .core_result(cres[0]), .core_busy(busy[0]));

  crypto_block_responder #(.TRIG_PRE(0), .TRIG_POST(0), .TIMEOUT(WD)) u_dut1 (
    .crypto_clk(clk), .crypto_rstn(rstn), .crypto_keyout(key), .crypto_textout(text),
    .crypto_start(start), .crypto_cipherin(cipher[1]), .crypto_ready(ready[1]),
    .crypto_done(done[1]), .crypto_idle(idle[1]), .trigger(trig[1]), .timeout(tmo[1]),
    .core_key(ckey[1]), .core_data(cdata[1]), .core_load(load[1]),
    .core_result(cres[1]), .core_busy(busy[1]));

  function automatic int pre_of(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  function automatic int post_of(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d] cyc=%0d got %h want %h", nm, idx, cyc, act, exp);
    end
  endtask

  // Cipher core stand-in: busy for cfg_b cycles starting the cycle after the load pulse.
  int bcnt [2] = '{0, 0};
  bit ld_seen [2] = '{1'b0, 1'b0};
  bit stuck_run [2] = '{1'b0, 1'b0};
  initial begin
    busy[0] = 1'b0; busy[1] = 1'b0; cres[0] = 128'd0; cres[1] = 128'd0;
  end
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (ld_seen[i]) begin
        bcnt[i] = cfg_b; stuck_run[i] = cfg_stuck; cres[i] = cfg_res; ld_seen[i] = 1'b0;
      end else if (bcnt[i] > 0) begin
        bcnt[i]--;
      end
      if (!cfg_stuck) stuck_run[i] = 1'b0;
      busy[i] = (bcnt[i] > 0) || stuck_run[i];
      if (load[i] === 1'b1) ld_seen[i] = 1'b1;
    end
  end

  // Operation-timeline model: an accepted op occupies D cycles, the result lands at offset cap.
  bit           chk_on = 1'b0;
  bit           m_prev = 1'b0;
  bit           m_act [2] = '{1'b0, 1'b0};
  bit           m_done [2] = '{1'b0, 1'b0};
  bit           m_to [2] = '{1'b0, 1'b0};
  bit           m_stuck [2] = '{1'b0, 1'b0};
  int           m_t0 [2] = '{0, 0};
  int           m_cap [2] = '{0, 0};
  int           m_d [2] = '{0, 0};
  logic [127:0] m_cipher [2];
  logic [127:0] m_res [2];
  logic [127:0] m_key [2];
  logic [127:0] m_data [2];

  always @(negedge clk) begin
    int p;
    if (chk_on) begin
      for (int i = 0; i < 2; i++) begin
        p = cyc - m_t0[i];
        chk("cipherin", i, cipher[i], m_cipher[i]);
        chk("ready", i, 128'(ready[i]), 128'(!m_act[i]));
        chk("idle", i, 128'(idle[i]), 128'(!m_act[i]));
        chk("trigger", i, 128'(trig[i]), 128'(m_act[i]));
        chk("done", i, 128'(done[i]), 128'(m_done[i]));
        chk("timeout", i, 128'(tmo[i]), 128'(m_to[i]));
        chk("core_load", i, 128'(load[i]), 128'(m_act[i] && (p == pre_of(i))));
        chk("core_key", i, ckey[i], m_key[i]);
        chk("core_data", i, cdata[i], m_data[i]);
      end
    end
    for (int i = 0; i < 2; i++) begin
      if (!rstn) begin
        m_act[i] = 1'b0; m_done[i] = 1'b0; m_to[i] = 1'b0;
        m_cipher[i] = 128'd0; m_key[i] = 128'd0; m_data[i] = 128'd0;
      end else begin
        if (!m_act[i] && start && !m_prev) begin
          m_act[i] = 1'b1; m_t0[i] = cyc + 1; m_stuck[i] = cfg_stuck; m_res[i] = cfg_res;
          m_key[i] = key; m_data[i] = text; m_done[i] = 1'b0; m_to[i] = 1'b0;
          m_cap[i] = cfg_stuck ? pre_of(i) + WD + 1 : pre_of(i) + cfg_b + 2;
          m_d[i] = m_cap[i] + post_of(i);
        end
        if (m_act[i]) begin
          p = cyc + 1 - m_t0[i];
          if (p == m_cap[i]) begin
            m_cipher[i] = m_stuck[i] ? 128'd0 : m_res[i];
            m_to[i] = m_stuck[i];
          end
          if (p == m_d[i]) begin
            m_act[i] = 1'b0; m_done[i] = 1'b1;
          end
        end
      end
    end
    m_prev = rstn ? start : 1'b0;
    if (!rstn) chk_on = 1'b1;
  end

  // Running totals for the literal checks.
  int tot_load [2] = '{0, 0};
  int tot_trig [2] = '{0, 0};
  int tot_drise [2] = '{0, 0};
  int done_rise [2] = '{0, 0};
  bit prev_done [2] = '{1'b0, 1'b0};
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (load[i] === 1'b1) tot_load[i]++;
      if (trig[i] === 1'b1) tot_trig[i]++;
      if (done[i] === 1'b1 && !prev_done[i]) begin
        tot_drise[i]++;
        done_rise[i] = cyc + 1;
      end
      prev_done[i] = (done[i] === 1'b1);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  int s_edge;
  int b_load [2];
  int b_trig [2];
  int b_drise [2];

  initial begin
    tick(3);
    rstn = 1'b1;
    tick(5);
    chk("lit_rst_ready", 0, 128'(ready[0]), 128'd1);
    chk("lit_rst_cipher", 0, cipher[0], 128'd0);
    chk("lit_no_load", 0, 128'(tot_load[0] + tot_load[1]), 128'd0);

    // Nominal AES vector; inputs change right after accept and must not matter.
    cfg_b = 10; cfg_res = AES_CT; key = AES_KEY; text = AES_PT;
    for (int i = 0; i < 2; i++) begin b_load[i] = tot_load[i]; b_trig[i] = tot_trig[i]; end
    s_edge = cyc + 1;
    pulse_start();
    key = 128'd0; text = 128'hffff;
    tick(30);
    chk("lit_nom_cipher", 0, cipher[0], AES_CT);
    chk("lit_nom_key", 0, ckey[0], AES_KEY);
    chk("lit_nom_loads", 0, 128'(tot_load[0] - b_load[0]), 128'd1);
    chk("lit_nom_done_at", 0, 128'(done_rise[0] - s_edge), 128'd17);
    chk("lit_nom_done_at", 1, 128'(done_rise[1] - s_edge), 128'd13);
    chk("lit_nom_trig_len", 0, 128'(tot_trig[0] - b_trig[0]), 128'd16);
    chk("lit_nom_trig_len", 1, 128'(tot_trig[1] - b_trig[1]), 128'd12);

    // Held start: one operation, then a fresh edge starts another.
    cfg_res = 128'h0123456789abcdef0011223344556677; key = 128'h5a5a; text = 128'ha5a5;
    b_load[0] = tot_load[0];
    start = 1'b1;
    tick(50);
    start = 1'b0;
    tick(5);
    chk("lit_held_loads", 0, 128'(tot_load[0] - b_load[0]), 128'd1);
    pulse_start();
    tick(30);
    chk("lit_held_again", 0, 128'(tot_load[0] - b_load[0]), 128'd2);

    // Second edge while RUN is in progress is dropped.
    cfg_res = 128'hdeadbeef_00000000_cafef00d_12345678;
    for (int i = 0; i < 2; i++) begin b_load[i] = tot_load[i]; b_drise[i] = tot_drise[i]; end
    pulse_start();
    tick(8);
    cfg_res = 128'd7;
    pulse_start();
    tick(30);
    chk("lit_busy_loads", 1, 128'(tot_load[1] - b_load[1]), 128'd1);
    chk("lit_busy_dones", 0, 128'(tot_drise[0] - b_drise[0]), 128'd1);
    chk("lit_busy_cipher", 0, cipher[0], 128'hdeadbeef_00000000_cafef00d_12345678);

    // Watchdog against a core whose busy never falls.
    cfg_stuck = 1'b1; cfg_res = 128'h1111;
    pulse_start();
    tick(40);
    chk("lit_wd_timeout", 0, 128'(tmo[0]), 128'd1);
    chk("lit_wd_cipher", 0, cipher[0], 128'd0);
    chk("lit_wd_done", 1, 128'(done[1]), 128'd1);
    cfg_stuck = 1'b0;
    tick(2);
    cfg_res = 128'h2222;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("lit_wd_clr_to", 0, 128'(tmo[0]), 128'd0);
    chk("lit_wd_clr_done", 0, 128'(done[0]), 128'd0);
    tick(30);

    // Reset in the middle of RUN, then a clean operation.
    cfg_res = 128'h3333;
    pulse_start();
    tick(6);
    rstn = 1'b0;
    tick(1);
    rstn = 1'b1;
    chk("lit_mid_rst_idle", 0, 128'(idle[0]), 128'd1);
    chk("lit_mid_rst_cipher", 0, cipher[0], 128'd0);
    tick(15);
    cfg_res = 128'h0f0e0d0c0b0a09080706050403020100;
    pulse_start();
    tick(30);
    chk("lit_after_rst", 0, cipher[0], 128'h0f0e0d0c0b0a09080706050403020100);
    chk("lit_after_rst", 1, cipher[1], 128'h0f0e0d0c0b0a09080706050403020100);
    tick(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
